video_timing_gen: RTL and testbench

- Raster timing source for the image-filter pipeline. It generates the i_vs/i_hs stream that the filter control block consumes, plus a data-enable and active-pixel coordinates.
- It drives the line-buffer writer and the optional test-pattern pixel path, and sits at the head of the filter datapath in place of a camera/HDMI receiver.

---
 rtl/video_timing_gen.sv | 171 +++++++++++++++++
 tb/tb_video_timing_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing source: h/v counters under an IDLE/RUN/STOP FSM, decoded into registered sync/DE/coords.
// Define VIDEO_TIMING_GEN_PATTERN_EN to add the diagonal-ramp test pattern on o_data (tied to 0 otherwise).
module video_timing_gen #(
   parameter int CNT_V_SIZE = 12,
   parameter int CNT_H_SIZE = 12,
   parameter int VSY        = 3,
   parameter int VBP        = 3,
   parameter int VAC        = 1080,
   parameter int VFP        = 3,
   parameter int HSY        = 1,
   parameter int HBP        = 3,
   parameter int HAC        = 1920,
   parameter int HFP        = 3,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_en,
   output logic                  o_vs,
   output logic                  o_hs,
   output logic                  o_de,
   output logic [CNT_H_SIZE-1:0] o_x,
   output logic [CNT_V_SIZE-1:0] o_y,
   output logic                  o_sof,
   output logic                  o_busy,
   output logic [15:0]           o_frame_cnt,
   output logic [DATA_WIDTH-1:0] o_data
);

   localparam int HTOT = HSY + HBP + HAC + HFP;
   localparam int VTOT = VSY + VBP + VAC + VFP;

   localparam logic [CNT_H_SIZE-1:0] H_LAST = CNT_H_SIZE'(HTOT - 1);
   localparam logic [CNT_H_SIZE-1:0] H_SY   = CNT_H_SIZE'(HSY);
   localparam logic [CNT_H_SIZE-1:0] H_A0   = CNT_H_SIZE'(HSY + HBP);
   localparam logic [CNT_H_SIZE-1:0] H_A1   = CNT_H_SIZE'(HSY + HBP + HAC);
   localparam logic [CNT_V_SIZE-1:0] V_LAST = CNT_V_SIZE'(VTOT - 1);
   localparam logic [CNT_V_SIZE-1:0] V_SY   = CNT_V_SIZE'(VSY);
   localparam logic [CNT_V_SIZE-1:0] V_A0   = CNT_V_SIZE'(VSY + VBP);
   localparam logic [CNT_V_SIZE-1:0] V_A1   = CNT_V_SIZE'(VSY + VBP + VAC);

   if (HTOT >= (2 ** CNT_H_SIZE)) begin : g_h_width_chk
      $error("video_timing_gen: HTOT does not fit in CNT_H_SIZE bits");
   end
   if (VTOT >= (2 ** CNT_V_SIZE)) begin : g_v_width_chk
      $error("video_timing_gen: VTOT does not fit in CNT_V_SIZE bits");
   end

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   state_t                  state_q, state_d;
   logic [CNT_H_SIZE-1:0]   h_cnt_q, h_cnt_d;
   logic [CNT_V_SIZE-1:0]   v_cnt_q, v_cnt_d;
   logic [15:0]             frame_cnt_q, frame_cnt_d;
   logic                    vs_q, vs_d;
   logic                    hs_q, hs_d;
   logic                    de_q, de_d;
   logic [CNT_H_SIZE-1:0]   x_q, x_d;
   logic [CNT_V_SIZE-1:0]   y_q, y_d;
   logic                    sof_q, sof_d;
   logic                    busy_q, busy_d;
   logic                    running;
   logic                    frame_end;

   assign running   = (state_q != IDLE);
   assign frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state: a frame is always finished; i_en only matters again at its last cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (i_en) state_d = RUN;
         RUN: begin
            if (frame_end)  state_d = i_en ? RUN : IDLE;
            else if (!i_en) state_d = STOP;
         end
         STOP: if (frame_end) state_d = i_en ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters and frame counter
   always_comb begin
      h_cnt_d     = '0;
      v_cnt_d     = '0;
      frame_cnt_d = frame_cnt_q;
      if (running) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_V_SIZE'(1);
         end else begin
            h_cnt_d = h_cnt_q + CNT_H_SIZE'(1);
            v_cnt_d = v_cnt_q;
         end
         if (frame_end) frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   // Output decode, registered below
   always_comb begin
      hs_d   = running && (h_cnt_q < H_SY);
      vs_d   = running && (v_cnt_q < V_SY);
      de_d   = running && (h_cnt_q >= H_A0) && (h_cnt_q < H_A1)
                       && (v_cnt_q >= V_A0) && (v_cnt_q < V_A1);
      x_d    = de_d ? (h_cnt_q - H_A0) : '0;
      y_d    = de_d ? (v_cnt_q - V_A0) : '0;
      sof_d  = running && (h_cnt_q == '0) && (v_cnt_q == '0);
      busy_d = running;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         frame_cnt_q <= '0;
         vs_q        <= 1'b0;
         hs_q        <= 1'b0;
         de_q        <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         sof_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         vs_q        <= vs_d;
         hs_q        <= hs_d;
         de_q        <= de_d;
         x_q         <= x_d;
         y_q         <= y_d;
         sof_q       <= sof_d;
         busy_q      <= busy_d;
      end
   end

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
   logic [DATA_WIDTH-1:0] data_q, data_d;

   // Diagonal ramp: top 3 bits are x^y, the rest are the low bits of x
   always_comb begin
      data_d = '0;
      if (de_d) data_d = {x_d[2:0] ^ y_d[2:0], x_d[DATA_WIDTH-4:0]};
   end

   always_ff @(posedge clk) begin
      if (!rstn) data_q <= '0;
      else       data_q <= data_d;
   end

   assign o_data = data_q;
`else
   assign o_data = '0;
`endif

   assign o_vs        = vs_q;
   assign o_hs        = hs_q;
   assign o_de        = de_q;
   assign o_x         = x_q;
   assign o_y         = y_q;
   assign o_sof       = sof_q;
   assign o_busy      = busy_q;
   assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen with an 8x6 raster (HTOT=8, VTOT=6).
// Cycle k = k-th clock after reset release with i_en=1; first o_sof is expected in cycle 2.
module tb_video_timing_gen;
   localparam int HW = 12;
   localparam int VW = 12;
   localparam int DW = 8;

   localparam int S_VS = 0, S_HS = 1, S_DE = 2, S_SOF = 3, S_BUSY = 4;
   localparam int S_FCNT = 5, S_X = 6, S_Y = 7, S_DATA = 8, S_ALLZ = 9;

   typedef struct { int cyc; int x; int y; int data; } beat_t;
   typedef struct { int cyc; int sig; int exp; } pt_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          i_en = 1'b0;
   logic          o_vs, o_hs, o_de, o_sof, o_busy;
   logic [HW-1:0] o_x;
   logic [VW-1:0] o_y;
   logic [15:0]   o_frame_cnt;
   logic [DW-1:0] o_data;

   video_timing_gen #(
      .CNT_V_SIZE(VW), .CNT_H_SIZE(HW),
      .VSY(1), .VBP(1), .VAC(3), .VFP(1),
      .HSY(1), .HBP(2), .HAC(4), .HFP(1),
      .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rstn(rstn), .i_en(i_en),
      .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de), .o_x(o_x), .o_y(o_y),
      .o_sof(o_sof), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt), .o_data(o_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int t0 = 0;
   int checks = 0;
   int failures = 0;

   beat_t de_q[$];
   int    sof_q[$];
   pt_t   pt_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int pat(input int x, input int y);
`ifdef VIDEO_TIMING_GEN_PATTERN_EN
      return (((x ^ y) & 7) << 5) | (x & 31);
`else
      return 0;
`endif
   endfunction

   function automatic string sig_name(input int s);
      case (s)
         S_VS: return "vs";       S_HS: return "hs";     S_DE: return "de";
         S_SOF: return "sof";     S_BUSY: return "busy"; S_FCNT: return "frame_cnt";
         S_X: return "x";         S_Y: return "y";       S_DATA: return "data";
         default: return "all_zero";
      endcase
   endfunction

   function automatic int sig_val(input int s);
      case (s)
         S_VS:   return int'(o_vs);
         S_HS:   return int'(o_hs);
         S_DE:   return int'(o_de);
         S_SOF:  return int'(o_sof);
         S_BUSY: return int'(o_busy);
         S_FCNT: return int'(o_frame_cnt);
         S_X:    return int'(o_x);
         S_Y:    return int'(o_y);
         S_DATA: return int'(o_data);
         default: return int'(o_vs | o_hs | o_de | o_sof | o_busy | (|o_x) | (|o_y)
                              | (|o_frame_cnt) | (|o_data));
      endcase
   endfunction

   // Monitor: pops expected DE beats / SOF pulses when the DUT presents them, plus timed point checks
   always @(negedge clk) begin
      int rel;
      beat_t b;
      int s;
      rel = cyc - t0;
      while (de_q.size() > 0 && de_q[0].cyc < rel) begin
         checks++; failures++;
         $display("FAIL de_missing: no o_de at cycle %0d (expected x=%0d y=%0d)", de_q[0].cyc, de_q[0].x, de_q[0].y);
         b = de_q.pop_front();
      end
      while (sof_q.size() > 0 && sof_q[0] < rel) begin
         checks++; failures++;
         $display("FAIL sof_missing: no o_sof at cycle %0d", sof_q[0]);
         s = sof_q.pop_front();
      end
      if (o_de) begin
         checks++;
         if (de_q.size() == 0 || de_q[0].cyc != rel) begin
            failures++;
            $display("FAIL de_extra: o_de=1 at cycle %0d, none expected (x=%0d y=%0d)", rel, o_x, o_y);
         end else begin
            b = de_q.pop_front();
            checks += 2;
            if (int'(o_x) != b.x || int'(o_y) != b.y) begin
               failures++;
               $display("FAIL de_xy cycle %0d: got x=%0d y=%0d, expected x=%0d y=%0d", rel, o_x, o_y, b.x, b.y);
            end
            if (int'(o_data) != b.data) begin
               failures++;
               $display("FAIL de_data cycle %0d: got 0x%0h, expected 0x%0h", rel, o_data, b.data);
            end
         end
      end
      if (o_sof) begin
         checks++;
         if (sof_q.size() == 0 || sof_q[0] != rel) begin
            failures++;
            $display("FAIL sof_extra: o_sof=1 at cycle %0d, none expected", rel);
         end else begin
            s = sof_q.pop_front();
         end
      end
      for (int i = pt_q.size() - 1; i >= 0; i--) begin
         if (pt_q[i].cyc == rel) begin
            checks++;
            if (sig_val(pt_q[i].sig) != pt_q[i].exp) begin
               failures++;
               $display("FAIL %s cycle %0d: got %0d, expected %0d", sig_name(pt_q[i].sig), rel,
                        sig_val(pt_q[i].sig), pt_q[i].exp);
            end
            pt_q.delete(i);
         end
      end
   end

   task automatic pt(input int c, input int s, input int e);
      pt_q.push_back('{c, s, e});
   endtask

   // Frame f (f-th back-to-back frame) has DE beats at cycles 21+48f+8y+x
   task automatic push_frame(input int f, input int last_cyc);
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 4; x++)
            if (21 + 48*f + 8*y + x <= last_cyc)
               de_q.push_back('{21 + 48*f + 8*y + x, x, y, pat(x, y)});
   endtask

   task automatic wait_rel(input int k);
      while (cyc - t0 < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start();
      rstn = 1'b0;
      i_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      t0   = cyc;
      rstn = 1'b1;
      i_en = 1'b1;
      pt(0, S_ALLZ, 0);
      pt(1, S_BUSY, 0);
      pt(2, S_BUSY, 1);
      sof_q.push_back(2);
   endtask

   initial begin
      // Continuous run: sync timing, two full frames, frame counter
      start();
      pt(1, S_VS, 0);  pt(2, S_VS, 1);  pt(9, S_VS, 1);  pt(10, S_VS, 0);
      pt(49, S_VS, 0); pt(50, S_VS, 1);
      pt(2, S_HS, 1);  pt(3, S_HS, 0);  pt(9, S_HS, 0);  pt(10, S_HS, 1);
      pt(17, S_HS, 0); pt(18, S_HS, 1);
      pt(20, S_DE, 0); pt(21, S_DE, 1); pt(24, S_X, 3);  pt(37, S_Y, 2);
      pt(20, S_DATA, 0); pt(32, S_DATA, pat(3, 1));
      pt(48, S_FCNT, 0); pt(49, S_FCNT, 1); pt(96, S_FCNT, 1); pt(97, S_FCNT, 2);
      push_frame(0, 1000); push_frame(1, 1000);
      sof_q.push_back(50); sof_q.push_back(98);
      wait_rel(105);

      // i_en dropped mid-frame: frame completes, then idle
      start();
      push_frame(0, 1000);
      pt(49, S_BUSY, 1); pt(50, S_BUSY, 0);
      pt(49, S_FCNT, 1); pt(70, S_FCNT, 1);
      pt(42, S_HS, 1);   pt(50, S_HS, 0); pt(58, S_HS, 0); pt(50, S_VS, 0);
      wait_rel(20); i_en = 1'b0;
      wait_rel(75);

      // i_en low pulse inside a frame: no gap between frames
      start();
      push_frame(0, 1000); push_frame(1, 1000);
      sof_q.push_back(50); sof_q.push_back(98);
      pt(49, S_BUSY, 1); pt(50, S_BUSY, 1); pt(50, S_VS, 1); pt(97, S_FCNT, 2);
      wait_rel(20); i_en = 1'b0;
      wait_rel(30); i_en = 1'b1;
      wait_rel(105);

      // Reset during active video, then a clean restart
      start();
      push_frame(0, 23);
      pt(23, S_BUSY, 1); pt(23, S_DE, 1); pt(24, S_ALLZ, 0); pt(25, S_ALLZ, 0);
      wait_rel(23); rstn = 1'b0;
      wait_rel(25);
      start();
      push_frame(0, 1000);
      sof_q.push_back(50);
      pt(49, S_FCNT, 1); pt(50, S_BUSY, 1);
      wait_rel(60);

      repeat (2) @(posedge clk);
      #1;
      if (de_q.size() != 0 || sof_q.size() != 0 || pt_q.size() != 0) begin
         $display("FAIL leftover_expectations: de=%0d sof=%0d pt=%0d, expected 0 0 0",
                  de_q.size(), sof_q.size(), pt_q.size());
         $fatal(1, "expectations left unchecked");
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
